// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   WIDTH-bit, CHANNELS-way registered multiplexer with valid/ready handshakes.
//   Arbitration is round-robin (ARB_MODE=0) or fixed priority with the lowest
//   index winning (ARB_MODE=1). A manual select (sel_en/sel) bypasses
//   arbitration. The output is a one-entry register that sustains one word
//   per cycle when drained and loaded on the same edge.
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready per-channel handshake (in_ready is combinational)
//   in_data           channel i at [i*WIDTH +: WIDTH]
//   sel_en, sel       manual channel select; sel >= CHANNELS grants nothing
//   out_valid/out_ready, out_data, out_chan  registered output stream
module rr_mux_arbiter #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      sel_en,
  input  logic [SEL_W-1:0]          sel,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SEL_W-1:0]  chan_q, chan_d;

  logic [CHANNELS-1:0] elig;
  logic [CHANNELS-1:0] grant;
  logic                grant_any;
  logic [SEL_W-1:0]    grant_idx;
  logic                load;
  int unsigned         scan_idx;

  assign load = (state_q == EMPTY) || out_ready;

  // Manual select keeps only the selected request; a sel value beyond the
  // channel count matches no bit, so the eligible set is empty.
  always_comb begin
    elig = '0;
    if (!sel_en) begin
      elig = in_valid;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (32'(sel) == i) elig[i] = in_valid[i];
      end
    end
  end

  // Scan order starts at rr_ptr (round-robin) or at 0 (fixed priority); the
  // first eligible index in that order wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      scan_idx = (ARB_MODE == 0) ? 32'(rr_ptr_q) + k : k;
      if (scan_idx >= CHANNELS) scan_idx = scan_idx - CHANNELS;
      if (!grant_any && elig[scan_idx]) begin
        grant_any        = 1'b1;
        grant_idx        = SEL_W'(scan_idx);
        grant[scan_idx]  = 1'b1;
      end
    end
  end

  // Gated by rst_n so no channel sees a handshake while reset is asserted.
  assign in_ready = (rst_n && load) ? grant : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    chan_d   = chan_q;
    if (load) begin
      if (grant_any) begin
        state_d = FULL;
        chan_d  = grant_idx;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (32'(grant_idx) == i) data_d = in_data[i*WIDTH +: WIDTH];
        end
        if (ARB_MODE == 0) begin
          rr_ptr_d = (32'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
        end
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      rr_ptr_q <= '0;
      data_q   <= '0;
      chan_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      chan_q   <= chan_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic        sel_en;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0]  rdy_rr, rdy_fp;
  logic        ov_rr, ov_fp;
  logic [15:0] od_rr, od_fp;
  logic [1:0]  oc_rr, oc_fp;

  logic [4:0]  in_valid5;
  logic [79:0] in_data5;
  logic [2:0]  sel5;
  logic [4:0]  rdy5;
  logic        ov5;
  logic [15:0] od5;
  logic [2:0]  oc5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(16), .CHANNELS(4), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_rr), .sel_en(sel_en), .sel(sel), .out_valid(ov_rr),
    .out_data(od_rr), .out_chan(oc_rr), .out_ready(out_ready));

  rr_mux_arbiter #(.WIDTH(16), .CHANNELS(4), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_fp), .sel_en(sel_en), .sel(sel), .out_valid(ov_fp),
    .out_data(od_fp), .out_chan(oc_fp), .out_ready(out_ready));

  rr_mux_arbiter #(.WIDTH(16), .CHANNELS(5), .ARB_MODE(0)) dut_n5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_data(in_data5),
    .in_ready(rdy5), .sel_en(sel_en), .sel(sel5), .out_valid(ov5),
    .out_data(od5), .out_chan(oc5), .out_ready(out_ready));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] chdata(input int i);
    return 16'(16'h1111 * (i + 1));
  endfunction

  task automatic load_default_data();
    for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = chdata(i);
  endtask

  typedef struct {
    logic [3:0] iv;
    logic       se;
    logic [1:0] s;
    logic [3:0] rdy_rr;
    int         oc_rr;
    logic [3:0] rdy_fp;
    int         oc_fp;
    logic       ov;
  } vec_t;

  vec_t tbl[$];

  // Reference model: arbitration by plain modular scan over the channel list
  int          m_ptr;
  logic        m_v[2];
  logic [15:0] m_d[2];
  int          m_c[2];

  function automatic int model_grant(input int mode, input logic [3:0] iv,
                                     input logic se, input logic [1:0] s, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (mode == 0) ? (ptr + k) % 4 : k;
      if (iv[idx] && (!se || int'(s) == idx)) return idx;
    end
    return -1;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = '0; sel_en = 1'b0; sel = '0; out_ready = 1'b1;
    in_data = '0; load_default_data();
    in_valid5 = '1; sel5 = '0;
    for (int i = 0; i < 5; i++) in_data5[i*16 +: 16] = 16'(16'h5000 + i);

    // Reset values
    #2;
    check("reset_ov_rr", 32'(ov_rr), 0);
    check("reset_od_rr", 32'(od_rr), 0);
    check("reset_oc_rr", 32'(oc_rr), 0);
    check("reset_rdy_rr", 32'(rdy_rr), 0);
    step(); step();
    rst_n = 1'b1;

    // Directed table: RR sequence, sparse RR + drain, manual select, fixed priority
    for (int k = 0; k < 8; k++)
      tbl.push_back('{4'hF, 1'b0, 2'd0, 4'(1 << (k % 4)), k % 4, 4'b0001, 0, 1'b1});
    tbl.push_back('{4'h9, 1'b0, 2'd0, 4'b0001, 0, 4'b0001, 0, 1'b1});
    tbl.push_back('{4'h9, 1'b0, 2'd0, 4'b1000, 3, 4'b0001, 0, 1'b1});
    tbl.push_back('{4'h9, 1'b0, 2'd0, 4'b0001, 0, 4'b0001, 0, 1'b1});
    tbl.push_back('{4'h9, 1'b0, 2'd0, 4'b1000, 3, 4'b0001, 0, 1'b1});
    tbl.push_back('{4'h0, 1'b0, 2'd0, 4'b0000, 3, 4'b0000, 0, 1'b0});
    for (int k = 0; k < 3; k++)
      tbl.push_back('{4'hF, 1'b1, 2'd2, 4'b0100, 2, 4'b0100, 2, 1'b1});
    tbl.push_back('{4'hF, 1'b0, 2'd0, 4'b1000, 3, 4'b0001, 0, 1'b1});
    tbl.push_back('{4'hA, 1'b0, 2'd0, 4'b0010, 1, 4'b0010, 1, 1'b1});
    tbl.push_back('{4'hA, 1'b0, 2'd0, 4'b1000, 3, 4'b0010, 1, 1'b1});
    tbl.push_back('{4'h8, 1'b0, 2'd0, 4'b1000, 3, 4'b1000, 3, 1'b1});

    foreach (tbl[r]) begin
      in_valid = tbl[r].iv; sel_en = tbl[r].se; sel = tbl[r].s; out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("tbl%0d_rdy_rr", r), 32'(rdy_rr), 32'(tbl[r].rdy_rr));
      check($sformatf("tbl%0d_rdy_fp", r), 32'(rdy_fp), 32'(tbl[r].rdy_fp));
      step();
      check($sformatf("tbl%0d_ov_rr", r), 32'(ov_rr), 32'(tbl[r].ov));
      check($sformatf("tbl%0d_ov_fp", r), 32'(ov_fp), 32'(tbl[r].ov));
      check($sformatf("tbl%0d_oc_rr", r), 32'(oc_rr), 32'(tbl[r].oc_rr));
      check($sformatf("tbl%0d_oc_fp", r), 32'(oc_fp), 32'(tbl[r].oc_fp));
      check($sformatf("tbl%0d_od_rr", r), 32'(od_rr), 32'(chdata(tbl[r].oc_rr)));
      check($sformatf("tbl%0d_od_fp", r), 32'(od_fp), 32'(chdata(tbl[r].oc_fp)));
    end
    sel_en = 1'b0;

    // Backpressure: BEEF held for 3 stalled cycles, then the next channel goes in
    in_data[15:0] = 16'hBEEF; in_valid = 4'b0001;
    step();
    check("bp_load_od_rr", 32'(od_rr), 32'hBEEF);
    check("bp_load_od_fp", 32'(od_fp), 32'hBEEF);
    out_ready = 1'b0; in_valid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_rdy_rr", 32'(rdy_rr), 0);
      check("bp_rdy_fp", 32'(rdy_fp), 0);
      step();
      check("bp_hold_od_rr", 32'(od_rr), 32'hBEEF);
      check("bp_hold_oc_rr", 32'(oc_rr), 0);
      check("bp_hold_ov_rr", 32'(ov_rr), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_rdy_rr", 32'(rdy_rr), 32'b0010);
    check("bp_release_rdy_fp", 32'(rdy_fp), 32'b0001);
    step();
    check("bp_release_oc_rr", 32'(oc_rr), 1);
    check("bp_release_od_rr", 32'(od_rr), 32'(chdata(1)));
    check("bp_release_od_fp", 32'(od_fp), 32'hBEEF);
    load_default_data();

    // Asynchronous reset while FULL (rr_ptr is 2 here)
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ov", 32'(ov_rr), 0);
    check("async_rst_od", 32'(od_rr), 0);
    check("async_rst_oc", 32'(oc_rr), 0);
    check("async_rst_rdy", 32'(rdy_rr), 0);
    step();
    check("in_rst_ov", 32'(ov_rr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ptr0_rdy", 32'(rdy_rr), 32'b0001);
    step();

    // Five-channel instance: legal sel, out-of-range sel, last channel and wrap
    sel_en = 1'b1; sel5 = 3'd3;
    @(negedge clk);
    check("n5_sel3_rdy", 32'(rdy5), 32'b01000);
    step();
    check("n5_sel3_oc", 32'(oc5), 3);
    check("n5_sel3_od", 32'(od5), 32'h5003);
    sel5 = 3'd5;
    @(negedge clk);
    check("n5_sel5_rdy", 32'(rdy5), 0);
    step();
    check("n5_sel5_ov", 32'(ov5), 0);
    check("n5_sel5_oc_kept", 32'(oc5), 3);
    sel5 = 3'd4;
    @(negedge clk);
    check("n5_sel4_rdy", 32'(rdy5), 32'b10000);
    step();
    check("n5_sel4_ov", 32'(ov5), 1);
    check("n5_sel4_oc", 32'(oc5), 4);
    sel_en = 1'b0;
    @(negedge clk);
    check("n5_wrap_rdy", 32'(rdy5), 32'b00001);
    step();

    // Randomized run against the reference model
    rst_n = 1'b0; in_valid = '0;
    step();
    rst_n = 1'b1;
    m_ptr = 0;
    for (int m = 0; m < 2; m++) begin m_v[m] = 1'b0; m_d[m] = '0; m_c[m] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = 4'($urandom_range(0, 15));
      sel_en    = ($urandom_range(0, 3) == 0);
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        int g;
        logic ld;
        logic [3:0] exp_rdy;
        g  = model_grant(m, in_valid, sel_en, sel, m_ptr);
        ld = !m_v[m] || out_ready;
        exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
        check($sformatf("rnd%0d_m%0d_rdy", cyc, m), 32'(m == 0 ? rdy_rr : rdy_fp), 32'(exp_rdy));
        check($sformatf("rnd%0d_m%0d_ov", cyc, m), 32'(m == 0 ? ov_rr : ov_fp), 32'(m_v[m]));
        check($sformatf("rnd%0d_m%0d_od", cyc, m), 32'(m == 0 ? od_rr : od_fp), 32'(m_d[m]));
        check($sformatf("rnd%0d_m%0d_oc", cyc, m), 32'(m == 0 ? oc_rr : oc_fp), 32'(m_c[m]));
        if (ld) begin
          if (g >= 0) begin
            m_v[m] = 1'b1;
            m_d[m] = in_data[g*16 +: 16];
            m_c[m] = g;
            if (m == 0) m_ptr = (g + 1) % 4;
          end else begin
            m_v[m] = 1'b0;
          end
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
